// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB with 2-bit counters; trains from EX outcome, flags mispredicts.
// Latency: lookup and mispredict/redirect are combinational; table update visible next cycle.
// Backpressure: none, so every ex_valid cycle is consumed; the caller inserts bubbles by dropping ex_valid.
module branch_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      ex_tag;
    logic                  ex_hit;
    logic [1:0]            ctr_next;

    // Word-aligned PCs: the two low bits never select or tag an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];

    // Fetch lookup straight from table state; a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && ctr_q[if_idx][1];
        pred_target = target_q[if_idx];
    end

    // Resolve check against what fetch predicted, plus the corrected fetch address.
    always_comb begin
        mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
    end

    // Training view of the resolving entry: hit test and saturating counter step.
    always_comb begin
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_next = ctr_q[ex_idx];
        if (ex_taken && ctr_q[ex_idx] != 2'b11)
            ctr_next = ctr_q[ex_idx] + 2'd1;
        else if (!ex_taken && ctr_q[ex_idx] != 2'b00)
            ctr_next = ctr_q[ex_idx] - 2'd1;
    end

    // Table write: train on hit, allocate (overwriting any alias) on miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_next;
                if (ex_taken)
                    target_q[ex_idx] <= ex_target;
            end else begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= ex_taken ? 2'b10 : 2'b01;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (ex_valid && branch_count != '1)
                branch_count <= branch_count + CNT_W'(1);
            if (mispredict && mispred_count != '1)
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        ex_taken, ex_pred_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count, mispred_count;

    logic        s_hit, s_taken, s_mp;
    logic [31:0] s_tgt, s_rd;
    logic [3:0]  s_bc, s_mc;

    int total = 0;
    int bad   = 0;

    // Expected {mispredict, redirect_pc} per resolve, produced when stimulus is driven.
    logic [32:0] sb[$];
    logic [32:0] exp_v;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    branch_predictor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_tgt),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(s_mp), .redirect_pc(s_rd),
        .branch_count(s_bc), .mispred_count(s_mc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one resolving branch and record what the outcome must be.
    task automatic drive_ex(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic tk, input logic ptk, input logic [31:0] ptgt);
        logic mp;
        logic [31:0] rd;
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_taken       = tk;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        mp = (tk != ptk) || (tk && ptk && (tgt != ptgt));
        rd = tk ? tgt : pc + 32'd4;
        sb.push_back({mp, rd});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; ex_pc = 32'h10; ex_target = 32'h0;
        ex_taken = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0; if_pc = 32'h100;
        #1;
        total++;
        if ({pred_hit, pred_taken, mispredict} !== 3'b000) begin
            bad++; $display("FAIL reset_pred: got hit/taken/mp=%b%b%b want 000", pred_hit, pred_taken, mispredict);
        end
        total++;
        if (redirect_pc !== 32'h14) begin
            bad++; $display("FAIL reset_redirect: got %h want 00000014", redirect_pc);
        end
        total++;
        if (branch_count !== 32'd0 || mispred_count !== 32'd0 || s_bc !== 4'd0 || s_mc !== 4'd0) begin
            bad++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want 0", branch_count, mispred_count, s_bc, s_mc);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_train();
        if_pc = 32'h100;
        #1;
        total++;
        if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL cold_lookup: got hit=%b taken=%b want 0 0", pred_hit, pred_taken);
        end
        drive_ex(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL first_resolve: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0; #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b11 || pred_target !== 32'h80) begin
            bad++; $display("FAIL trained_lookup: got hit=%b taken=%b tgt=%h want 1 1 00000080", pred_hit, pred_taken, pred_target);
        end
        for (int i = 0; i < 2; i++) begin
            drive_ex(32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
            #2;
            exp_v = sb.pop_front(); total++;
            if ({mispredict, redirect_pc} !== exp_v) begin
                bad++; $display("FAIL taken_again_%0d: got %h want %h", i, {mispredict, redirect_pc}, exp_v);
            end
            tick();
        end
        drive_ex(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL not_taken_resolve: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0; #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b11) begin
            bad++; $display("FAIL ctr_from_sat: got hit=%b taken=%b want 1 1", pred_hit, pred_taken);
        end
        drive_ex(32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL second_not_taken: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0; #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b10 || pred_target !== 32'h80) begin
            bad++; $display("FAIL ctr_weak_nt: got hit=%b taken=%b tgt=%h want 1 0 00000080", pred_hit, pred_taken, pred_target);
        end
        total++;
        if (branch_count !== 32'd5 || mispred_count !== 32'd3) begin
            bad++; $display("FAIL counts_train: got %0d/%0d want 5/3", branch_count, mispred_count);
        end
    endtask

    task automatic test_not_taken();
        drive_ex(32'h200, 32'h999, 1'b0, 1'b0, 32'h0);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL nt_correct: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick();
        drive_ex(32'h200, 32'h304, 1'b1, 1'b1, 32'h300);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL wrong_target: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0; #1;
        total++;
        if (mispredict !== 1'b0) begin
            bad++; $display("FAIL idle_mispredict: got %b want 0", mispredict);
        end
    endtask

    task automatic test_alias();
        drive_ex(32'h100, 32'h80, 1'b1, 1'b0, 32'h0);
        tick(); void'(sb.pop_front());
        drive_ex(32'h1100, 32'h2000, 1'b0, 1'b0, 32'h0);
        #2;
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL alias_resolve: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0;
        if_pc = 32'h100; #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("FAIL alias_evicted: got hit=%b want 0", pred_hit);
        end
        if_pc = 32'h1100; #1;
        total++;
        if ({pred_hit, pred_taken} !== 2'b10) begin
            bad++; $display("FAIL alias_new: got hit=%b taken=%b want 1 0", pred_hit, pred_taken);
        end
        total++;
        if (branch_count !== 32'd9 || mispred_count !== 32'd5) begin
            bad++; $display("FAIL counts_alias: got %0d/%0d want 9/5", branch_count, mispred_count);
        end
    endtask

    task automatic test_same_cycle_and_reset();
        if_pc = 32'h100;
        drive_ex(32'h100, 32'h40, 1'b1, 1'b0, 32'h0);
        #2;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("FAIL same_cycle_no_bypass: got hit=%b want 0", pred_hit);
        end
        exp_v = sb.pop_front(); total++;
        if ({mispredict, redirect_pc} !== exp_v) begin
            bad++; $display("FAIL same_cycle_resolve: got %h want %h", {mispredict, redirect_pc}, exp_v);
        end
        tick(); ex_valid = 1'b0; #1;
        total++;
        if (pred_hit !== 1'b1 || pred_target !== 32'h40) begin
            bad++; $display("FAIL next_cycle_visible: got hit=%b tgt=%h want 1 00000040", pred_hit, pred_target);
        end
        drive_ex(32'h300, 32'h500, 1'b1, 1'b0, 32'h0);
        void'(sb.pop_front());
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (pred_hit !== 1'b0 || branch_count !== 32'd0 || mispred_count !== 32'd0) begin
            bad++; $display("FAIL mid_reset: got hit=%b counts=%0d/%0d want 0 0/0", pred_hit, branch_count, mispred_count);
        end
        tick(); ex_valid = 1'b0;
        if_pc = 32'h300; #1;
        total++;
        if (pred_hit !== 1'b0) begin
            bad++; $display("FAIL update_discarded: got hit=%b want 0", pred_hit);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            drive_ex(32'h400 + 32'(i) * 32'd4, 32'h800, 1'b1, 1'b0, 32'h0);
            #2;
            exp_v = sb.pop_front(); total++;
            if ({mispredict, redirect_pc} !== exp_v) begin
                bad++; $display("FAIL sat_resolve_%0d: got %h want %h", i, {mispredict, redirect_pc}, exp_v);
            end
            tick();
        end
        ex_valid = 1'b0; #1;
        total++;
        if (s_bc !== 4'd15 || s_mc !== 4'd15) begin
            bad++; $display("FAIL sat_counters: got %0d/%0d want 15/15", s_bc, s_mc);
        end
        total++;
        if (branch_count !== 32'd20 || mispred_count !== 32'd20) begin
            bad++; $display("FAIL wide_counters: got %0d/%0d want 20/20", branch_count, mispred_count);
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_not_taken();
        test_alias();
        test_same_cycle_and_reset();
        test_saturate();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
